// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store.
// One transaction in flight; a timer forces an error completion on a dead slave.
module memory_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Ifetch_Req,
  input  logic [XLEN-1:0]   i_Ifetch_Addr,
  output logic [XLEN-1:0]   o_Ifetch_Data,
  output logic              o_Ifetch_Done,
  input  logic              i_Data_Req,
  input  logic [XLEN-1:0]   i_Data_Addr,
  input  logic              i_Data_Write_Enable,
  input  logic [XLEN-1:0]   i_Data_Write_Data,
  input  logic [XLEN/8-1:0] i_Data_Strobe,
  output logic [XLEN-1:0]   o_Data_Read_Data,
  output logic              o_Data_Done,
  output logic              o_Error,
  output logic              o_Mem_Req_Valid,
  input  logic              i_Mem_Req_Ready,
  output logic [XLEN-1:0]   o_Mem_Addr,
  output logic              o_Mem_Write_Enable,
  output logic [XLEN-1:0]   o_Mem_Write_Data,
  output logic [XLEN/8-1:0] o_Mem_Strobe,
  input  logic              i_Mem_Resp_Valid,
  input  logic [XLEN-1:0]   i_Mem_Resp_Data,
  input  logic              i_Mem_Resp_Error,
  output logic              o_Busy,
  output logic              o_Grant
);

  localparam int SW = XLEN / 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    DONE
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic            last_q;
  logic            grant_q;
  logic            req_valid_q;
  logic [XLEN-1:0] addr_q;
  logic            we_q;
  logic [XLEN-1:0] wdata_q;
  logic [SW-1:0]   strb_q;
  logic [XLEN-1:0] fdata_q;
  logic [XLEN-1:0] ddata_q;
  logic            fdone_q;
  logic            ddone_q;
  logic            err_q;

  logic            grant_d;
  logic            tmo_d;
  logic            fin_d;
  logic            fin_err_d;
  logic [XLEN-1:0] fin_data_d;

  // Tie goes to whoever did not win last time.
  always_comb begin
    grant_d = i_Data_Req;
    if (i_Ifetch_Req && i_Data_Req) begin
      grant_d = ~last_q;
    end
  end

  // A real accept or response in the timeout cycle wins over the timeout.
  always_comb begin
    tmo_d      = (timer_q >= TW'(TIMEOUT_CYCLES - 1));
    fin_d      = 1'b0;
    fin_err_d  = 1'b1;
    fin_data_d = '0;
    if (state_q == ISSUE) begin
      fin_d = ~i_Mem_Req_Ready & tmo_d;
    end else if (state_q == WAIT_RESP) begin
      fin_d = i_Mem_Resp_Valid | tmo_d;
      if (i_Mem_Resp_Valid) begin
        fin_err_d  = i_Mem_Resp_Error;
        fin_data_d = i_Mem_Resp_Data;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      fdata_q     <= '0;
      ddata_q     <= '0;
      fdone_q     <= 1'b0;
      ddone_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fdone_q <= 1'b0;
      ddone_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_Ifetch_Req || i_Data_Req) begin
            state_q     <= ISSUE;
            timer_q     <= '0;
            grant_q     <= grant_d;
            last_q      <= grant_d;
            req_valid_q <= 1'b1;
            addr_q      <= grant_d ? i_Data_Addr : i_Ifetch_Addr;
            we_q        <= grant_d & i_Data_Write_Enable;
            wdata_q     <= grant_d ? i_Data_Write_Data : '0;
            strb_q      <= grant_d ? i_Data_Strobe : '0;
          end
        end
        ISSUE, WAIT_RESP: begin
          timer_q <= timer_q + TW'(1);
          if (fin_d) begin
            state_q     <= DONE;
            req_valid_q <= 1'b0;
            err_q       <= fin_err_d;
            if (grant_q) begin
              ddone_q <= 1'b1;
              ddata_q <= fin_data_d;
            end else begin
              fdone_q <= 1'b1;
              fdata_q <= fin_data_d;
            end
          end else if (state_q == ISSUE && i_Mem_Req_Ready) begin
            state_q     <= WAIT_RESP;
            req_valid_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_Ifetch_Data      = fdata_q;
  assign o_Ifetch_Done      = fdone_q;
  assign o_Data_Read_Data   = ddata_q;
  assign o_Data_Done        = ddone_q;
  assign o_Error            = err_q;
  assign o_Mem_Req_Valid    = req_valid_q;
  assign o_Mem_Addr         = addr_q;
  assign o_Mem_Write_Enable = we_q;
  assign o_Mem_Write_Data   = wdata_q;
  assign o_Mem_Strobe       = strb_q;
  assign o_Busy             = (state_q != IDLE);
  assign o_Grant            = grant_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed scoreboard bench for memory_port_arbiter.
// A small round-robin model predicts owners; expected completions are queued.
module tb_memory_port_arbiter;

  localparam int XLEN = 32;
  localparam int SW   = 4;
  localparam int TMO  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            f_req;
  logic [XLEN-1:0] f_addr;
  logic [XLEN-1:0] f_rdata;
  logic            f_done;
  logic            d_req;
  logic [XLEN-1:0] d_addr;
  logic            d_we;
  logic [XLEN-1:0] d_wdata;
  logic [SW-1:0]   d_strb;
  logic [XLEN-1:0] d_rdata;
  logic            d_done;
  logic            err;
  logic            m_valid;
  logic            m_ready;
  logic [XLEN-1:0] m_addr;
  logic            m_we;
  logic [XLEN-1:0] m_wdata;
  logic [SW-1:0]   m_strb;
  logic            r_valid;
  logic [XLEN-1:0] r_data;
  logic            r_err;
  logic            busy;
  logic            grant;

  memory_port_arbiter #(
    .XLEN(XLEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_Clock            (clk),
    .i_Reset            (rst),
    .i_Ifetch_Req       (f_req),
    .i_Ifetch_Addr      (f_addr),
    .o_Ifetch_Data      (f_rdata),
    .o_Ifetch_Done      (f_done),
    .i_Data_Req         (d_req),
    .i_Data_Addr        (d_addr),
    .i_Data_Write_Enable(d_we),
    .i_Data_Write_Data  (d_wdata),
    .i_Data_Strobe      (d_strb),
    .o_Data_Read_Data   (d_rdata),
    .o_Data_Done        (d_done),
    .o_Error            (err),
    .o_Mem_Req_Valid    (m_valid),
    .i_Mem_Req_Ready    (m_ready),
    .o_Mem_Addr         (m_addr),
    .o_Mem_Write_Enable (m_we),
    .o_Mem_Write_Data   (m_wdata),
    .o_Mem_Strobe       (m_strb),
    .i_Mem_Resp_Valid   (r_valid),
    .i_Mem_Resp_Data    (r_data),
    .i_Mem_Resp_Error   (r_err),
    .o_Busy             (busy),
    .o_Grant            (grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            owner;
    logic [XLEN-1:0] data;
    logic            err;
  } exp_t;

  exp_t            sbq[$];
  int              checks = 0;
  int              errors = 0;
  logic            last_m;
  logic [XLEN-1:0] fdata_m;
  logic [XLEN-1:0] ddata_m;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (m_valid !== 1'b1 && n < 30) begin
      cyc();
      n++;
    end
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
  endtask

  task automatic grant_chk(input string tag, output logic own);
    own = d_req;
    if (f_req && d_req) own = ~last_m;
    last_m = own;
    chk({tag, "_grant"}, 32'(grant), 32'(own));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_addr"}, m_addr, own ? d_addr : f_addr);
    chk({tag, "_we"}, 32'(m_we), own ? 32'(d_we) : 32'd0);
    chk({tag, "_strb"}, 32'(m_strb), own ? 32'(d_strb) : 32'd0);
    if (own) chk({tag, "_wdata"}, m_wdata, d_wdata);
  endtask

  task automatic done_chk(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sbq_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    if (e.owner) ddata_m = e.data;
    else fdata_m = e.data;
    chk({tag, "_dones"}, {30'd0, f_done, d_done}, e.owner ? 32'd1 : 32'd2);
    chk({tag, "_owner"}, 32'(grant), 32'(e.owner));
    chk({tag, "_err"}, 32'(err), 32'(e.err));
    chk({tag, "_fdata"}, f_rdata, fdata_m);
    chk({tag, "_ddata"}, d_rdata, ddata_m);
  endtask

  task automatic post_chk(input string tag);
    cyc();
    chk({tag, "_post_dones"}, {30'd0, f_done, d_done}, 32'd0);
    chk({tag, "_post_err"}, 32'(err), 32'd0);
    chk({tag, "_post_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic serve(input string tag, input int rdelay, input int respdelay,
                       input logic [XLEN-1:0] rdata, input logic rerr,
                       input logic drop);
    logic            own;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] w;
    wait_valid(tag);
    grant_chk(tag, own);
    sbq.push_back('{owner: own, data: rdata, err: rerr});
    a = m_addr;
    w = m_wdata;
    for (int i = 0; i < rdelay; i++) begin
      cyc();
      chk({tag, "_hold_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_hold_addr"}, m_addr, a);
      chk({tag, "_hold_wdata"}, m_wdata, w);
    end
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(m_valid), 32'd0);
    repeat (respdelay - 1) cyc();
    r_valid = 1'b1;
    r_data  = rdata;
    r_err   = rerr;
    cyc();
    r_valid = 1'b0;
    r_data  = $urandom;
    r_err   = 1'b0;
    done_chk(tag);
    if (drop) begin
      f_req = 1'b0;
      d_req = 1'b0;
    end
    post_chk(tag);
  endtask

  initial begin
    int   n;
    logic own;
    rst = 1'b1;
    f_req = 1'b0;
    f_addr = '0;
    d_req = 1'b0;
    d_addr = '0;
    d_we = 1'b0;
    d_wdata = '0;
    d_strb = '0;
    m_ready = 1'b0;
    r_valid = 1'b0;
    r_data = '0;
    r_err = 1'b0;
    last_m = 1'b1;
    fdata_m = '0;
    ddata_m = '0;
    cyc();
    cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_addr", m_addr, 32'd0);
    chk("rst_outs", {26'd0, f_done, d_done, err, m_we, |m_strb, |m_wdata}, 32'd0);
    chk("rst_rdata", f_rdata | d_rdata, 32'd0);
    rst = 1'b0;
    cyc();

    // 1: single fetch, valid one cycle after Req
    f_req = 1'b1;
    f_addr = 32'h100;
    cyc();
    chk("t1_latency", 32'(m_valid), 32'd1);
    serve("t1", 0, 3, 32'hDEADBEEF, 1'b0, 1'b1);

    // 2: both requesters held high from reset
    rst = 1'b1;
    f_req = 1'b1;
    d_req = 1'b1;
    f_addr = 32'h1000;
    d_addr = 32'h2000;
    d_we = 1'b0;
    cyc();
    rst = 1'b0;
    last_m = 1'b1;
    fdata_m = '0;
    ddata_m = '0;
    serve("t2a", 0, 2, 32'h11111111, 1'b0, 1'b0);
    chk("t2a_owner_fetch", 32'(last_m), 32'd0);
    serve("t2b", 0, 2, 32'h22222222, 1'b0, 1'b0);
    chk("t2b_owner_data", 32'(last_m), 32'd1);
    serve("t2c", 1, 2, 32'h33333333, 1'b0, 1'b0);
    chk("t2c_owner_fetch", 32'(last_m), 32'd0);
    serve("t2d", 0, 1, 32'h44444444, 1'b0, 1'b1);
    chk("t2d_owner_data", 32'(last_m), 32'd1);

    // 3: store with ready low for 5 cycles
    d_req = 1'b1;
    d_addr = 32'h200;
    d_we = 1'b1;
    d_wdata = 32'h12345678;
    d_strb = 4'hF;
    serve("t3", 5, 1, 32'h0BADF00D, 1'b0, 1'b1);
    d_we = 1'b0;
    d_strb = 4'h0;

    // 4: fetch accepted, slave never responds
    f_req = 1'b1;
    f_addr = 32'h300;
    wait_valid("t4");
    grant_chk("t4", own);
    sbq.push_back('{owner: own, data: 32'h0, err: 1'b1});
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    n = 1;
    while (f_done !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("t4_tmo_latency", 32'(n), 32'd8);
    done_chk("t4");
    f_req = 1'b0;
    cyc();
    r_valid = 1'b1;
    r_data = 32'h55555555;
    chk("t4_idle", 32'(busy), 32'd0);
    cyc();
    r_valid = 1'b0;
    chk("t4_late_dones", {30'd0, f_done, d_done}, 32'd0);
    chk("t4_late_fdata", f_rdata, fdata_m);
    chk("t4_late_busy", 32'(busy), 32'd0);
    f_req = 1'b1;
    f_addr = 32'h304;
    serve("t4n", 0, 2, 32'hA5A5A5A5, 1'b0, 1'b1);

    // 5: slave error on a load, then a clean load
    d_req = 1'b1;
    d_addr = 32'h500;
    serve("t5e", 0, 2, 32'hAAAA5555, 1'b1, 1'b0);
    d_addr = 32'h504;
    serve("t5ok", 0, 2, 32'h5555AAAA, 1'b0, 1'b1);

    // 6: reset while waiting for the response
    d_req = 1'b1;
    d_addr = 32'h400;
    wait_valid("t6");
    grant_chk("t6", own);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    chk("t6_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    last_m = 1'b1;
    fdata_m = '0;
    ddata_m = '0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valid", 32'(m_valid), 32'd0);
    chk("t6_dones", {30'd0, f_done, d_done}, 32'd0);
    chk("t6_ddata", d_rdata, 32'd0);
    d_addr = 32'h408;
    serve("t6n", 0, 2, 32'hFEEDFACE, 1'b0, 1'b1);

    chk("sbq_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
